pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register with a two-entry skid buffer. It generalises the fixed 16-bit fetch/decode latch into a reusable stage for any boundary in the five-stage processor. It carries an instruction field plus an arbitrary-width side payload (PC, PC+2, control bits), and uses valid/ready handshakes on both sides. Flush inserts a NOP bubble, and the stage sustains full throughput under back-pressure without a combinational ready path.

## Interface
Parameters:
- INSTR_W, 16, width of the instruction field
- PAYLOAD_W, 32, width of the side payload (e.g. {pc_plus_2, currPC})
- NOP_INSTR, 16'h0800, instruction value presented whenever the stage holds no valid entry

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream offers an entry
- in_ready  output  1  stage can accept; driven from a register only
- in_instr  input  INSTR_W  upstream instruction
- in_payload  input  PAYLOAD_W  upstream payload
- flush  input  1  discard all held entries and the current input
- out_valid  output  1  downstream entry valid
- out_ready  input  1  downstream consumes the entry
- out_instr  output  INSTR_W  held instruction, or NOP_INSTR when empty
- out_payload  output  PAYLOAD_W  held payload, or 0 when empty
- occupancy  output  2  number of held entries (0, 1 or 2)

## Operation
- Internal state: main entry (main_v, main_instr, main_payload) drives the outputs directly. Skid entry (skid_v, skid_instr, skid_payload) sits behind it.
- Invariant: skid_v = 1 implies main_v = 1.
- in_ready = !skid_v. out_valid = main_v. occupancy = main_v + skid_v.
- accept = in_valid & in_ready. consume = main_v & out_ready.
- States and transitions when flush = 0:
  - EMPTY (0 entries): accept → ONE, main loads the input. No accept → EMPTY.
  - ONE: consume & accept → ONE, main loads the input. Consume only → EMPTY. Accept only → FULL, skid loads the input. Neither → ONE, hold.
  - FULL (in_ready = 0): consume → ONE, main loads skid and skid is cleared. No consume → FULL, hold.
- Flush has top priority. The next state is EMPTY regardless of accept or consume. The input entry is dropped, and the outputs present NOP_INSTR and a payload of 0.
- Whenever main_v becomes 0, main_instr is loaded with NOP_INSTR and main_payload with 0. Downstream therefore always sees a NOP when out_valid = 0, even if it ignores out_valid.
- When skid is cleared, its data registers load NOP_INSTR and 0.
- Data passes through unmodified. There is no width conversion; the field widths are fixed by the parameters.

## Timing
- Reset (asynchronous, immediate): out_valid = 0, out_instr = NOP_INSTR, out_payload = 0, in_ready = 1, occupancy = 0. Reset asserted mid-operation discards all entries immediately.
- Latency: an entry accepted at edge N appears on out_* after edge N, i.e. one cycle.
- Throughput: one entry per cycle while out_ready = 1.
- in_ready falls on the edge after the skid fills and rises on the edge after the skid drains. Upstream may see in_ready = 1 for one cycle while the main entry is stalled; the skid absorbs that beat.
- Entries leave in strict FIFO order. None are duplicated or dropped except by flush or rst.
- Flush takes effect at the edge on which it is sampled. in_ready = 1 in the following cycle.
- flush and in_valid in the same cycle: the input is not retained, even though in_ready = 1 means the upstream handshake completes.

## Test plan
- Reset then idle: assert rst mid-cycle with no clock → out_valid = 0, out_instr = 16'h0800, out_payload = 0, in_ready = 1, occupancy = 0, all at once.
- Streaming: push instr 16'h1000..16'h1004 with out_ready = 1 every cycle → the same five values appear on out_instr one cycle later, back-to-back, with in_ready held at 1.
- Back-pressure: push A = 16'hA000, B = 16'hB000, C = 16'hC000 with out_ready = 0 → occupancy goes 1 then 2, in_ready = 0 after B, and C is held upstream. Releasing out_ready then gives the order A, B, C with no loss.
- Flush with a full stage: occupancy = 2 plus flush = 1 and in_valid = 1 → next cycle occupancy = 0, out_valid = 0, out_instr = 16'h0800, in_ready = 1, and the input is dropped.
- Simultaneous consume and accept in ONE: main = A, out_ready = 1, in_valid = 1 with B → next cycle out_instr = B, occupancy = 1, and the skid remains empty.
- Parameter sweep: INSTR_W = 32, PAYLOAD_W = 64, NOP_INSTR = 32'h00000013 → the streaming and flush scenarios pass with the new NOP value when empty.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//
// Flow-controlled pipeline stage register with a two-entry skid buffer. It carries an
// instruction field and a side payload between two valid/ready interfaces. in_ready comes
// straight from a flop, so there is no combinational path from out_ready to in_ready. The
// stage still sustains one entry per cycle under back-pressure, because the skid entry
// absorbs the beat accepted while the main entry is stalled.
//
// Parameters:
//   INSTR_W    width of the instruction field
//   PAYLOAD_W  width of the side payload
//   NOP_INSTR  instruction presented whenever the stage holds no valid entry
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     upstream offers an entry
//   in_ready     stage can accept (registered)
//   in_instr     upstream instruction
//   in_payload   upstream payload
//   flush        drop all held entries and the current input
//   out_valid    downstream entry valid
//   out_ready    downstream consumes the entry
//   out_instr    held instruction, or NOP_INSTR when empty
//   out_payload  held payload, or 0 when empty
//   occupancy    number of held entries (0..2)

module pipe_stage_reg #(
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned PAYLOAD_W = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy
);

    // Main entry drives the outputs; skid entry sits behind it.
    logic                 main_v_q, main_v_d;
    logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
    logic [PAYLOAD_W-1:0] main_payload_q, main_payload_d;
    logic                 skid_v_q, skid_v_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;

    logic accept;
    logic consume;

    assign in_ready    = ~skid_v_q;
    assign accept      = in_valid & in_ready;
    assign consume     = main_v_q & out_ready;

    assign out_valid   = main_v_q;
    assign out_instr   = main_instr_q;
    assign out_payload = main_payload_q;
    assign occupancy   = {1'b0, main_v_q} + {1'b0, skid_v_q};

    always_comb begin
        main_v_d       = main_v_q;
        main_instr_d   = main_instr_q;
        main_payload_d = main_payload_q;
        skid_v_d       = skid_v_q;
        skid_instr_d   = skid_instr_q;
        skid_payload_d = skid_payload_q;

        if (flush) begin
            // Flush wins over everything, and the input beat is discarded even though
            // the upstream handshake completes.
            main_v_d       = 1'b0;
            main_instr_d   = NOP_INSTR;
            main_payload_d = '0;
            skid_v_d       = 1'b0;
            skid_instr_d   = NOP_INSTR;
            skid_payload_d = '0;
        end else begin
            unique case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (accept) begin
                        main_v_d       = 1'b1;
                        main_instr_d   = in_instr;
                        main_payload_d = in_payload;
                    end
                end
                2'b10: begin
                    if (consume && accept) begin
                        main_instr_d   = in_instr;
                        main_payload_d = in_payload;
                    end else if (consume) begin
                        main_v_d       = 1'b0;
                        main_instr_d   = NOP_INSTR;
                        main_payload_d = '0;
                    end else if (accept) begin
                        skid_v_d       = 1'b1;
                        skid_instr_d   = in_instr;
                        skid_payload_d = in_payload;
                    end
                end
                2'b11: begin
                    if (consume) begin
                        main_instr_d   = skid_instr_q;
                        main_payload_d = skid_payload_q;
                        skid_v_d       = 1'b0;
                        skid_instr_d   = NOP_INSTR;
                        skid_payload_d = '0;
                    end
                end
                default: begin
                    // Skid valid without main valid breaks the invariant; recover to empty.
                    main_v_d       = 1'b0;
                    main_instr_d   = NOP_INSTR;
                    main_payload_d = '0;
                    skid_v_d       = 1'b0;
                    skid_instr_d   = NOP_INSTR;
                    skid_payload_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q       <= 1'b0;
            main_instr_q   <= NOP_INSTR;
            main_payload_q <= '0;
            skid_v_q       <= 1'b0;
            skid_instr_q   <= NOP_INSTR;
            skid_payload_q <= '0;
        end else begin
            main_v_q       <= main_v_d;
            main_instr_q   <= main_instr_d;
            main_payload_q <= main_payload_d;
            skid_v_q       <= skid_v_d;
            skid_instr_q   <= skid_instr_d;
            skid_payload_q <= skid_payload_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default-width instance and a 32/64-bit instance
// with a RISC-V style NOP, sharing clock and reset.

module tb_pipe_stage_reg;

    logic clk;
    logic rst;

    // Default instance (16-bit instr, 32-bit payload, NOP 16'h0800).
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] in_instr, out_instr;
    logic [31:0] in_payload, out_payload;
    logic [1:0]  occupancy;

    // Wide instance (32-bit instr, 64-bit payload, NOP 32'h13).
    logic        w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready;
    logic [31:0] w_in_instr, w_out_instr;
    logic [63:0] w_in_payload, w_out_payload;
    logic [1:0]  w_occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_reg dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_payload  (in_payload),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_payload (out_payload),
        .occupancy   (occupancy)
    );

    pipe_stage_reg #(
        .INSTR_W   (32),
        .PAYLOAD_W (64),
        .NOP_INSTR (32'h0000_0013)
    ) dut_w (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (w_in_valid),
        .in_ready    (w_in_ready),
        .in_instr    (w_in_instr),
        .in_payload  (w_in_payload),
        .flush       (w_flush),
        .out_valid   (w_out_valid),
        .out_ready   (w_out_ready),
        .out_instr   (w_out_instr),
        .out_payload (w_out_payload),
        .occupancy   (w_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, ".instr"}, {48'd0, out_instr}, 64'h0800);
        check({tag, ".payload"}, {32'd0, out_payload}, 64'd0);
        check({tag, ".ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, ".occ"}, {62'd0, occupancy}, 64'd0);
    endtask

    task automatic check_out(input string tag, input logic [15:0] instr, input logic [1:0] occ);
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".instr"}, {48'd0, out_instr}, {48'd0, instr});
        check({tag, ".payload"}, {32'd0, out_payload}, {48'd0, instr} + 64'h100);
        check({tag, ".occ"}, {62'd0, occupancy}, {62'd0, occ});
    endtask

    task automatic push(input logic [15:0] instr);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_payload = {16'd0, instr} + 32'h100;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_payload = '0; flush = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_instr = '0; w_in_payload = '0; w_flush = 1'b0;
        w_out_ready = 1'b0;
        #1;
        check_empty("reset");
        check("reset.w_instr", {32'd0, w_out_instr}, 64'h13);
        check("reset.w_payload", w_out_payload, 64'd0);
        step();
        step();
        rst = 1'b0;

        // Streaming: five back-to-back entries with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(16'h1000 + 16'(i));
            check("stream.in_ready", {63'd0, in_ready}, 64'd1);
            step();
            check_out("stream", 16'h1000 + 16'(i), 2'd1);
        end
        in_valid = 1'b0;
        step();
        check_empty("stream_drain");

        // Back-pressure: A, B fill the stage, C is held upstream.
        out_ready = 1'b0;
        push(16'hA000);
        step();
        check_out("bp_a", 16'hA000, 2'd1);
        check("bp_a.ready", {63'd0, in_ready}, 64'd1);
        push(16'hB000);
        step();
        check_out("bp_b", 16'hA000, 2'd2);
        check("bp_b.ready", {63'd0, in_ready}, 64'd0);
        push(16'hC000);
        step();
        check_out("bp_c_held", 16'hA000, 2'd2);
        out_ready = 1'b1;
        step();
        check_out("bp_rel_b", 16'hB000, 2'd1);
        check("bp_rel_b.ready", {63'd0, in_ready}, 64'd1);
        step();
        check_out("bp_rel_c", 16'hC000, 2'd1);
        in_valid = 1'b0;
        step();
        check_empty("bp_drain");

        // Flush a full stage while a new input is offered.
        out_ready = 1'b0;
        push(16'hA001);
        step();
        push(16'hB001);
        step();
        check("fl_full.occ", {62'd0, occupancy}, 64'd2);
        push(16'hD001);
        flush = 1'b1;
        step();
        check_empty("flush");
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        check_empty("flush_dropped");

        // Consume and accept in the same cycle from ONE.
        push(16'hA002);
        step();
        check_out("ca_a", 16'hA002, 2'd1);
        out_ready = 1'b1;
        push(16'hB002);
        step();
        check_out("ca_b", 16'hB002, 2'd1);
        check("ca_b.ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        step();
        check_empty("ca_drain");

        // Asynchronous reset mid-cycle with the stage full.
        out_ready = 1'b0;
        push(16'hA003);
        step();
        push(16'hB003);
        step();
        in_valid = 1'b0;
        check("mr_full.occ", {62'd0, occupancy}, 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check_empty("mid_reset");
        #1;
        rst = 1'b0;
        step();
        check_empty("after_reset");

        // Wide instance: streaming then flush, NOP is 32'h13 when empty.
        w_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_in_valid   = 1'b1;
            w_in_instr   = 32'h1234_0000 + 32'(i);
            w_in_payload = 64'hDEAD_0000_0000_0000 + 64'(i);
            step();
            check("w_stream.valid", {63'd0, w_out_valid}, 64'd1);
            check("w_stream.instr", {32'd0, w_out_instr}, 64'h1234_0000 + 64'(i));
            check("w_stream.payload", w_out_payload, 64'hDEAD_0000_0000_0000 + 64'(i));
        end
        w_in_valid = 1'b0;
        step();
        check("w_drain.valid", {63'd0, w_out_valid}, 64'd0);
        check("w_drain.instr", {32'd0, w_out_instr}, 64'h13);
        w_out_ready  = 1'b0;
        w_in_valid   = 1'b1;
        w_in_instr   = 32'hAAAA_0001;
        w_in_payload = 64'h1;
        step();
        w_in_instr   = 32'hBBBB_0002;
        w_in_payload = 64'h2;
        step();
        check("w_full.occ", {62'd0, w_occupancy}, 64'd2);
        w_in_instr = 32'hCCCC_0003;
        w_flush    = 1'b1;
        step();
        w_flush    = 1'b0;
        w_in_valid = 1'b0;
        check("w_flush.occ", {62'd0, w_occupancy}, 64'd0);
        check("w_flush.valid", {63'd0, w_out_valid}, 64'd0);
        check("w_flush.instr", {32'd0, w_out_instr}, 64'h13);
        check("w_flush.payload", w_out_payload, 64'd0);
        check("w_flush.ready", {63'd0, w_in_ready}, 64'd1);
        step();
        check("w_flush_dropped.valid", {63'd0, w_out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
